kpscan: RTL and testbench
=========================

KPSCAN -- requirements
Module: kpscan

Interface
REQ-001 Parameter NROWS, default 4, keypad row count (2..8).
REQ-002 Parameter NCOLS, default 4, keypad column count (2..8).
REQ-003 Parameter DWELL, default 4, clk cycles each column is driven per scan step (>=2).
REQ-004 Parameter DEBOUNCE, default 3, consecutive identical dwell samples that confirm a press or release (>=1).
REQ-005 clk  input  1  clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 kpr  input  NROWS  row sense, active-low; all-ones means no key.
REQ-008 kpc  output  NCOLS  column drive, one-cold, active-low.
REQ-009 key_code  output  $clog2(NROWS*NCOLS)  code = row*NCOLS + col.
REQ-010 key_valid  output  1  code available, held until accepted.
REQ-011 key_ready  input  1  consumer accepts the code when key_valid && key_ready.
REQ-012 key_held  output  1  high while a confirmed key remains pressed.
REQ-013 overflow  output  1  sticky; a confirmed press was dropped because key_valid was still pending.

Function
REQ-014 Dwell counter counts 0..DWELL-1 and wraps; kpr is sampled only when the count is DWELL-1 (the "sample point").
REQ-015 FSM states are SCAN, DEBOUNCE, HELD and RELEASE.
REQ-016 SCAN: at a sample point with kpr all-ones, kpc rotates right by one position (the low bit wraps to bit NCOLS-1) and the column index decrements modulo NCOLS.
REQ-017 SCAN: at a sample point with any kpr bit low, the state goes to DEBOUNCE, kpc freezes, the row pattern is latched and the match count is set to 1.
REQ-018 DEBOUNCE: each sample equal to the latched pattern increments the match count; when the count reaches DEBOUNCE the press is confirmed and the state goes to HELD.
REQ-019 DEBOUNCE: a sample that differs from the latched pattern returns the state to SCAN and rotates kpc in the same cycle; no code is emitted.
REQ-020 DEBOUNCE=1: the press is confirmed at the first low sample, with a one-cycle pass through DEBOUNCE.
REQ-021 Multiple rows low: the lowest-index low row sets key_code.
REQ-022 On confirmation, if key_valid is low or key_ready is high in the same cycle, key_code and key_valid=1 register on the next clk edge (latency 1 cycle from the confirming sample).
REQ-023 On confirmation with key_valid high and key_ready low, key_code is kept, the new code is dropped and overflow is set.
REQ-024 A handshake (key_valid && key_ready) clears key_valid on the next edge unless a new code loads in the same cycle.
REQ-025 HELD: key_held=1 and kpc stays frozen; a sample with kpr all-ones goes to RELEASE with the release count set to 1.
REQ-026 RELEASE: each all-ones sample increments the release count; at DEBOUNCE the state goes to SCAN and kpc rotates.
REQ-027 RELEASE: any low sample returns the state to HELD; no new code is emitted (no auto-repeat).
REQ-028 overflow clears only on reset.

Reset
REQ-029 Asynchronous reset gives kpc bit NCOLS-1 low and all other bits high (4-col: 0111), column index NCOLS-1, state SCAN, dwell and match counters 0.
REQ-030 Reset also gives key_valid=0, key_code=0, key_held=0 and overflow=0.
REQ-031 Reset mid-debounce or mid-hold abandons the press; no code is emitted after reset is released.

Structure
REQ-032 Shared package kpscan_pkg holds the state enum type and the code-width function clog2-based helper.
REQ-033 One sub-module, kpscan_dwell, provides the parametrised dwell counter and its sample-point strobe.

Verification
REQ-034 Reset release, no key, DWELL=4 -> kpc 0111, 1011, 1101, 1110, 0111, changing every 4 cycles.
REQ-035 Row 2 held low from the moment column 1 is driven, DEBOUNCE=3 -> key_valid rises 1 cycle after the 3rd sample, key_code=9, key_held=1.
REQ-036 Bounce: row low for 2 samples, then high -> no key_valid, and kpc resumes rotation with 1101→1110.
REQ-037 Two confirmed presses with key_ready=0 -> first code retained and overflow=1; then key_ready=1 for 1 cycle -> key_valid=0.
REQ-038 Rows 1 and 3 low on column 0 -> key_code=4.
REQ-039 Reset asserted in HELD -> kpc=0111, key_held=0, key_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/kpscan_pkg.sv
// Shared types and helpers for the keypad scanner.
// Holds the scanner state encoding and the key-code width helper.
package kpscan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  function automatic int code_width(input int nrows, input int ncols);
    return (nrows * ncols > 1) ? $clog2(nrows * ncols) : 1;
  endfunction

endpackage

// File: rtl/kpscan_dwell.sv
// Dwell counter for the keypad scanner: counts 0..DWELL-1 and wraps.
// o_sample marks the last cycle of each dwell, when the rows are sampled.
module kpscan_dwell #(
  parameter int DWELL = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sample
);

  localparam int DW = $clog2(DWELL);
  localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

  logic [DW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + DW'(1);
  end

  assign o_sample = (r_cnt == LAST);

endmodule

// File: rtl/kpscan.sv
// Keypad matrix scanner: one-cold column drive, debounced press/release,
// and a single-entry valid/ready code output with a sticky overflow flag.
//
// state       | meaning
// ST_SCAN     | rotating the driven column, looking for any low row
// ST_DEBOUNCE | column frozen, counting samples equal to the latched rows
// ST_HELD     | press confirmed, waiting for all rows to go high
// ST_RELEASE  | counting all-high samples before resuming the scan
module kpscan
  import kpscan_pkg::*;
#(
  parameter int NROWS    = 4,
  parameter int NCOLS    = 4,
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NROWS-1:0]                      kpr,
  output logic [NCOLS-1:0]                      kpc,
  output logic [code_width(NROWS, NCOLS)-1:0]   key_code,
  output logic                                  key_valid,
  input  logic                                  key_ready,
  output logic                                  key_held,
  output logic                                  overflow
);

  localparam int CW  = code_width(NROWS, NCOLS);
  localparam int RW  = $clog2(NROWS);
  localparam int CLW = $clog2(NCOLS);
  localparam int MW  = $clog2(DEBOUNCE + 1);
  localparam logic [MW:0] DB_TC = (MW + 1)'(DEBOUNCE);

  state_t           r_state, w_state_nx;
  logic [NCOLS-1:0] r_kpc;
  logic [CLW-1:0]   r_col;
  logic [NROWS-1:0] r_pat;
  logic [MW-1:0]    r_match, w_match_nx;
  logic [CW-1:0]    r_code, w_code;
  logic             r_valid, r_ovf;
  logic             w_sample, w_idle, w_same, w_rotate, w_latch, w_confirm;
  logic [MW:0]      w_match_inc;
  logic [RW-1:0]    w_row;

  kpscan_dwell #(.DWELL(DWELL)) u_dwell (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .o_sample (w_sample)
  );

  assign w_idle      = &kpr;
  assign w_same      = (kpr == r_pat);
  assign w_match_inc = {1'b0, r_match} + (MW + 1)'(1);

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    w_row = '0;
    for (int i = NROWS - 1; i >= 0; i--)
      if (!r_pat[i]) w_row = RW'(i);
    w_code = CW'(int'(w_row) * NCOLS + int'(r_col));
  end

  // A count already at DEBOUNCE on entry only happens when DEBOUNCE is 1;
  // that case resolves in one cycle without waiting for another sample.
  always_comb begin
    w_state_nx = r_state;
    w_match_nx = r_match;
    w_rotate   = 1'b0;
    w_latch    = 1'b0;
    w_confirm  = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_sample) begin
          if (w_idle) begin
            w_rotate = 1'b1;
          end else begin
            w_state_nx = ST_DEBOUNCE;
            w_latch    = 1'b1;
            w_match_nx = MW'(1);
          end
        end
      end
      ST_DEBOUNCE: begin
        if ({1'b0, r_match} >= DB_TC) begin
          w_confirm  = 1'b1;
          w_state_nx = ST_HELD;
        end else if (w_sample) begin
          if (w_same) begin
            w_match_nx = w_match_inc[MW-1:0];
            if (w_match_inc == DB_TC) begin
              w_confirm  = 1'b1;
              w_state_nx = ST_HELD;
            end
          end else begin
            w_state_nx = ST_SCAN;
            w_rotate   = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (w_sample && w_idle) begin
          w_state_nx = ST_RELEASE;
          w_match_nx = MW'(1);
        end
      end
      ST_RELEASE: begin
        if ({1'b0, r_match} >= DB_TC) begin
          w_state_nx = ST_SCAN;
          w_rotate   = 1'b1;
        end else if (w_sample) begin
          if (w_idle) begin
            w_match_nx = w_match_inc[MW-1:0];
            if (w_match_inc == DB_TC) begin
              w_state_nx = ST_SCAN;
              w_rotate   = 1'b1;
            end
          end else begin
            w_state_nx = ST_HELD;
          end
        end
      end
      default: w_state_nx = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_SCAN;
      r_kpc   <= {1'b0, {(NCOLS - 1){1'b1}}};
      r_col   <= CLW'(NCOLS - 1);
      r_pat   <= '1;
      r_match <= '0;
    end else begin
      r_state <= w_state_nx;
      r_match <= w_match_nx;
      if (w_rotate) begin
        r_kpc <= {r_kpc[0], r_kpc[NCOLS-1:1]};
        r_col <= (r_col == '0) ? CLW'(NCOLS - 1) : r_col - CLW'(1);
      end
      if (w_latch) r_pat <= kpr;
    end
  end

  // A pending code is never overwritten; a press arriving then is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_confirm && (!r_valid || key_ready)) begin
        r_code  <= w_code;
        r_valid <= 1'b1;
      end else begin
        if (w_confirm) r_ovf <= 1'b1;
        if (r_valid && key_ready) r_valid <= 1'b0;
      end
    end
  end

  assign kpc       = r_kpc;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign overflow  = r_ovf;
  assign key_held  = (r_state == ST_HELD) || (r_state == ST_RELEASE);

endmodule

// File: tb/tb_kpscan.sv
// Directed bench for kpscan at default parameters (4x4, DWELL=4, DEBOUNCE=3).
// Inputs change and outputs are checked on the falling clock edge.
module tb_kpscan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  kpscan dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kpr       (kpr),
    .kpc       (kpc),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Returns on the falling edge right after kpc changes to pat.
  task automatic wait_kpc(input logic [3:0] pat);
    logic [3:0] prev;
    logic       found;
    prev  = kpc;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick(1);
      if (kpc == pat && prev != pat) found = 1'b1;
      prev = kpc;
    end
    chk("wait_kpc_reached", {31'd0, found}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    kpr       = 4'b1111;
    key_ready = 1'b0;
    tick(2);
    chk("rst_kpc",   {28'd0, kpc}, 32'h7);
    chk("rst_code",  {28'd0, key_code}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_held",  {31'd0, key_held}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;

    // Idle rotation, one column step every 4 cycles.
    tick(3); chk("rot_hold0", {28'd0, kpc}, 32'h7);
    tick(1); chk("rot_1011",  {28'd0, kpc}, 32'hB);
    tick(3); chk("rot_hold1", {28'd0, kpc}, 32'hB);
    tick(1); chk("rot_1101",  {28'd0, kpc}, 32'hD);
    tick(4); chk("rot_1110",  {28'd0, kpc}, 32'hE);
    tick(4); chk("rot_0111",  {28'd0, kpc}, 32'h7);

    // Row 2 pressed while column 1 is driven.
    wait_kpc(4'b1101);
    kpr = 4'b1011;
    tick(11);
    chk("press_valid_early", {31'd0, key_valid}, 32'd0);
    tick(1);
    chk("press_valid", {31'd0, key_valid}, 32'd1);
    chk("press_code",  {28'd0, key_code}, 32'd9);
    chk("press_held",  {31'd0, key_held}, 32'd1);
    chk("press_kpc",   {28'd0, kpc}, 32'hD);
    key_ready = 1'b1;
    tick(1);
    chk("hs_valid_clr", {31'd0, key_valid}, 32'd0);
    key_ready = 1'b0;
    kpr = 4'b1111;
    tick(10);
    chk("rel_kpc_frozen", {28'd0, kpc}, 32'hD);
    chk("rel_held",       {31'd0, key_held}, 32'd1);
    tick(1);
    chk("rel_kpc_rot", {28'd0, kpc}, 32'hE);
    chk("rel_unheld",  {31'd0, key_held}, 32'd0);
    chk("rel_no_rep",  {31'd0, key_valid}, 32'd0);

    // Bounce: two low samples then high aborts the press.
    wait_kpc(4'b1101);
    kpr = 4'b1110;
    tick(8);
    kpr = 4'b1111;
    tick(3);
    chk("bnc_kpc_frozen", {28'd0, kpc}, 32'hD);
    tick(1);
    chk("bnc_kpc_rot", {28'd0, kpc}, 32'hE);
    chk("bnc_valid",   {31'd0, key_valid}, 32'd0);
    tick(4);
    chk("bnc_resume", {28'd0, kpc}, 32'h7);

    // Rows 1 and 3 low on column 0: lowest row wins.
    wait_kpc(4'b1110);
    kpr = 4'b0101;
    tick(12);
    chk("multi_valid", {31'd0, key_valid}, 32'd1);
    chk("multi_code",  {28'd0, key_code}, 32'd4);
    kpr = 4'b1111;

    // Second press while the first code is still pending.
    wait_kpc(4'b0111);
    kpr = 4'b1110;
    tick(11);
    chk("ovf_early", {31'd0, overflow}, 32'd0);
    tick(1);
    chk("ovf_set",   {31'd0, overflow}, 32'd1);
    chk("ovf_code",  {28'd0, key_code}, 32'd4);
    chk("ovf_valid", {31'd0, key_valid}, 32'd1);
    chk("ovf_held",  {31'd0, key_held}, 32'd1);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    chk("ovf_hs_clr",  {31'd0, key_valid}, 32'd0);
    chk("ovf_sticky",  {31'd0, overflow}, 32'd1);
    tick(3);

    // Asynchronous reset while held.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_kpc",   {28'd0, kpc}, 32'h7);
    chk("arst_held",  {31'd0, key_held}, 32'd0);
    chk("arst_valid", {31'd0, key_valid}, 32'd0);
    chk("arst_code",  {28'd0, key_code}, 32'd0);
    chk("arst_ovf",   {31'd0, overflow}, 32'd0);
    kpr = 4'b1111;
    @(negedge clk);
    reset_n = 1'b1;
    tick(40);
    chk("post_rst_valid", {31'd0, key_valid}, 32'd0);
    chk("post_rst_held",  {31'd0, key_held}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
